// File: rtl/muladd_6464_pkg.sv
// muladd_6464_pkg: shared widths, FSM encoding and size clamp for the multiply-accumulate
package muladd_6464_pkg;
  localparam int W = 64;
  localparam int SW = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic logic [SW-1:0] clamp_size(input logic [SW-1:0] s);
    return s > SW'(W) ? SW'(W) : s;
  endfunction
endpackage

// File: rtl/muladd_6464_add_128.sv
// add_128: conditional 2W-bit accumulate step, acc + (en ? addend : 0)
module add_128
  import muladd_6464_pkg::*;
(
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] addend,
  input  logic           en,
  output logic [2*W-1:0] sum
);
  assign sum = acc + (en ? addend : '0);
endmodule

// File: rtl/muladd_6464.sv
// muladd_6464: sequential shift-add result = (q mod 2^size)*b + r over min(size,W) cycles
module muladd_6464
  import muladd_6464_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  q,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  r,
  input  logic [SW-1:0] size,
  output logic [2*W-1:0] result,
  output logic          ready_n,
  output logic          busy
);
  state_t state, state_nx;
  logic [W-1:0] q_sh;
  logic [2*W-1:0] b_sh, acc, sum;
  logic [SW-1:0] cnt, size_c;
  logic load, last;
  assign size_c = clamp_size(size);
  assign load = start && state != ST_RUN;
  assign last = state == ST_RUN && cnt == SW'(1);
  add_128 u_add (.acc(acc), .addend(b_sh), .en(q_sh[0]), .sum(sum));
  always_ff @(posedge clk)
    state <= rst ? ST_IDLE : state_nx;
  always_comb
    state_nx = load ? (size_c == '0 ? ST_DONE : ST_RUN) : last ? ST_DONE : state;
  always_comb begin
    busy = state == ST_RUN;
    ready_n = state != ST_DONE;
  end
  // result is written only on DONE entry so partial sums never leak out
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      cnt <= '0;
      result <= '0;
    end else if (load) begin
      q_sh <= q;
      b_sh <= {W'(0), b};
      acc <= {W'(0), r};
      cnt <= size_c;
      if (size_c == '0) result <= {W'(0), r};
    end else if (state == ST_RUN) begin
      acc <= sum;
      b_sh <= b_sh << 1;
      q_sh <= q_sh >> 1;
      cnt <= cnt - SW'(1);
      if (last) result <= sum;
    end
  end
endmodule
